// File: rtl/act_unit_scheduler_if.sv
// Requester/response bus shared by the activation-unit scheduler and its clients.
// master = requester side, slave = scheduler side.
interface act_unit_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 18,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_data;

  modport master (
    output req_valid, req_data,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/act_unit_scheduler.sv
// Round-robin scheduler sharing one pipelined activation unit among NREQ clients.
// Optional ACT_ISSUE_CNT_EN adds a 32-bit issue_cnt of act_start pulses.
module act_unit_scheduler #(
  parameter int QN   = 6,
  parameter int QM   = 11,
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int II   = 2,
  localparam int W   = QN + QM + 1,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  act_unit_scheduler_if.slave    bus,
  output logic                   act_start,
  output logic [W-1:0]           act_operand,
  input  logic [W-1:0]           act_result,
  output logic                   busy
`ifdef ACT_ISSUE_CNT_EN
  ,
  output logic [31:0]            issue_cnt
`endif
);

  localparam int GW = (II > 1) ? $clog2(II) : 1;

  logic [IDW-1:0]  ptr;
  logic [GW-1:0]   gap_cnt;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  idx;
  logic [IDW-1:0]  ptr_nxt;
  logic [IDW-1:0]  act_id;
  logic [LAT-1:0]  tag_v;
  logic [IDW-1:0]  tag_id [LAT];

  // Scan from the pointer upward, wrapping; first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    if (!reset && gap_cnt == '0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = IDW'((int'(ptr) + k) % NREQ);
        if (!gnt_any && bus.req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (gnt_any)
      bus.req_ready[gnt_id] = 1'b1;
  end

  assign ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      gap_cnt     <= '0;
      act_start   <= 1'b0;
      act_operand <= '0;
      act_id      <= '0;
    end else begin
      if (gnt_any) begin
        ptr     <= ptr_nxt;
        gap_cnt <= GW'(II - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      act_start <= gnt_any;
      if (gnt_any) begin
        act_operand <= bus.req_data[gnt_id*W +: W];
        act_id      <= gnt_id;
      end
    end
  end

  // Tag stage LAT-1 is valid exactly when act_result belongs to it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v <= '0;
      for (int i = 0; i < LAT; i++)
        tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= act_start;
      tag_id[0] <= act_id;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_data  <= '0;
    end else begin
      bus.resp_valid <= tag_v[LAT-1];
      if (tag_v[LAT-1]) begin
        bus.resp_id   <= tag_id[LAT-1];
        bus.resp_data <= act_result;
      end
    end
  end

  assign busy = act_start | (|tag_v) | bus.resp_valid;

`ifdef ACT_ISSUE_CNT_EN
  logic [31:0] icnt;

  always_ff @(posedge clk) begin
    if (reset)
      icnt <= '0;
    else if (act_start)
      icnt <= icnt + 32'd1;
  end

  assign issue_cnt = icnt;
`endif

endmodule
